// File: rtl/sdram_mport_ctrl.sv
// rtl/sdram_mport_ctrl.sv - multi-channel SDRAM write/read port arbiter with burst address generation
// Define SDRAM_MPORT_BUFROT_EN for NBUF-buffer frame rotation; otherwise every channel wraps linearly in buffer 0.
module sdram_mport_ctrl #(
  parameter int CH        = 2,
  parameter int ADDR_W    = 24,
  parameter int LEN_W     = 10,
  parameter int BUF_SHIFT = 20,
  parameter int NBUF      = 3,
  localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk_ref,
  input  logic                    rst,
  input  logic                    sdram_init_done,
  input  logic [CH*BUF_SHIFT-1:0] wr_min_addr,
  input  logic [CH*BUF_SHIFT-1:0] wr_max_addr,
  input  logic [CH*BUF_SHIFT-1:0] rd_min_addr,
  input  logic [CH*BUF_SHIFT-1:0] rd_max_addr,
  input  logic [LEN_W-1:0]        wr_length,
  input  logic [LEN_W-1:0]        rd_length,
  input  logic [CH-1:0]           wr_load,
  input  logic [CH-1:0]           rd_load,
  input  logic [CH-1:0]           rd_valid,
  input  logic [CH*LEN_W-1:0]     wrf_use,
  input  logic [CH*LEN_W-1:0]     rdf_use,
  output logic [CH-1:0]           wrf_clr,
  output logic [CH-1:0]           rdf_clr,
  output logic                    sdram_wr_req,
  output logic                    sdram_rd_req,
  input  logic                    sdram_wr_ack,
  input  logic                    sdram_rd_ack,
  output logic [ADDR_W-1:0]       sdram_wr_addr,
  output logic [ADDR_W-1:0]       sdram_rd_addr,
  output logic [CH_W-1:0]         sdram_ch
);

  localparam int BI_W = (NBUF > 2) ? 2 : 1;
  localparam int OW   = BUF_SHIFT + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST} state_t;

  state_t               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [CH_W-1:0]      ch_q, ch_d, wr_rr_q, wr_rr_d, rd_rr_q, rd_rr_d;
  logic                 wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic                 ack_r_q, ack_r_d, kill_q, kill_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [BUF_SHIFT-1:0] wr_off_q [CH];
  logic [BUF_SHIFT-1:0] wr_off_d [CH];
  logic [BUF_SHIFT-1:0] rd_off_q [CH];
  logic [BUF_SHIFT-1:0] rd_off_d [CH];
  logic [CH-1:0]        wr_load_r_q, wr_load_r_d, rd_load_r_q, rd_load_r_d;
  logic [CH-1:0]        wr_edge_q, wr_edge_d, rd_edge_q, rd_edge_d;
  logic [CH-1:0]        wrf_clr_q, wrf_clr_d, rdf_clr_q, rdf_clr_d;
  logic [BI_W-1:0]      wr_bidx [CH];
  logic [BI_W-1:0]      rd_bidx [CH];
`ifdef SDRAM_MPORT_BUFROT_EN
  logic [BI_W-1:0]      wr_buf_q [CH];
  logic [BI_W-1:0]      wr_buf_d [CH];
  logic [BI_W-1:0]      rd_buf_q [CH];
  logic [BI_W-1:0]      rd_buf_d [CH];
  logic [BI_W-1:0]      last_done_q [CH];
  logic [BI_W-1:0]      last_done_d [CH];
  logic [CH-1:0]        done_valid_q, done_valid_d;
`endif
  logic                 ack;
  logic [OW-1:0]        nxt;
  logic                 found;
  int                   sel;

  function automatic logic [BUF_SHIFT-1:0] fld(input logic [CH*BUF_SHIFT-1:0] v, input int i);
    return v[i*BUF_SHIFT +: BUF_SHIFT];
  endfunction

  function automatic logic [LEN_W-1:0] lvl(input logic [CH*LEN_W-1:0] v, input int i);
    return v[i*LEN_W +: LEN_W];
  endfunction

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [BI_W-1:0] b, input logic [BUF_SHIFT-1:0] o);
    return (ADDR_W'(b) << BUF_SHIFT) | ADDR_W'(o);
  endfunction

`ifdef SDRAM_MPORT_BUFROT_EN
  // Writer never lands on the buffer the reader is showing, except in ping-pong mode.
  function automatic logic [BI_W-1:0] next_wbuf(input logic [BI_W-1:0] w, input logic [BI_W-1:0] r);
    logic [BI_W-1:0] n;
    n = (w == BI_W'(NBUF-1)) ? '0 : w + 1'b1;
    if (NBUF >= 3 && n == r) n = (n == BI_W'(NBUF-1)) ? '0 : n + 1'b1;
    return n;
  endfunction
`endif

  assign ack = dir_q ? sdram_wr_ack : sdram_rd_ack;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
`ifdef SDRAM_MPORT_BUFROT_EN
      wr_bidx[i] = wr_buf_q[i];
      rd_bidx[i] = rd_buf_q[i];
`else
      wr_bidx[i] = '0;
      rd_bidx[i] = '0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;  dir_d = dir_q;  ch_d = ch_q;
    wr_rr_d = wr_rr_q;  rd_rr_d = rd_rr_q;
    wr_req_d = wr_req_q;  rd_req_d = rd_req_q;
    wr_addr_d = wr_addr_q;  rd_addr_d = rd_addr_q;
    kill_d = kill_q;  ack_r_d = ack;
    wr_off_d = wr_off_q;  rd_off_d = rd_off_q;
`ifdef SDRAM_MPORT_BUFROT_EN
    wr_buf_d = wr_buf_q;  rd_buf_d = rd_buf_q;
    last_done_d = last_done_q;  done_valid_d = done_valid_q;
`endif
    wr_load_r_d = wr_load;  rd_load_r_d = rd_load;
    wr_edge_d = wr_load & ~wr_load_r_q;
    rd_edge_d = rd_load & ~rd_load_r_q;
    wrf_clr_d = wr_edge_q;  rdf_clr_d = rd_edge_q;
    nxt = '0;  found = 1'b0;  sel = 0;

    case (state_q)
      S_IDLE: if (sdram_init_done) begin
        for (int k = 1; k <= CH; k++) begin
          sel = (int'(wr_rr_q) + k) % CH;
          if (!found && lvl(wrf_use, sel) >= wr_length) begin
            found = 1'b1;  dir_d = 1'b1;  ch_d = CH_W'(sel);  wr_rr_d = CH_W'(sel);
            kill_d = wr_edge_q[sel];  wr_req_d = 1'b1;  state_d = S_REQ;
            wr_addr_d = mk_addr(wr_bidx[sel], wr_off_q[sel]);
          end
        end
        for (int k = 1; k <= CH; k++) begin
          sel = (int'(rd_rr_q) + k) % CH;
          if (!found && rd_valid[sel] && lvl(rdf_use, sel) < rd_length) begin
            found = 1'b1;  dir_d = 1'b0;  ch_d = CH_W'(sel);  rd_rr_d = CH_W'(sel);
            kill_d = rd_edge_q[sel];  rd_req_d = 1'b1;  state_d = S_REQ;
            rd_addr_d = mk_addr(rd_bidx[sel], rd_off_q[sel]);
          end
        end
      end
      S_REQ: if (ack) begin
        wr_req_d = 1'b0;  rd_req_d = 1'b0;  state_d = S_BURST;
      end
      S_BURST: if (ack_r_q && !ack) begin
        state_d = S_IDLE;
        if (!kill_q && dir_q) begin
          nxt = {1'b0, wr_off_q[ch_q]} + OW'(wr_length);
          if (nxt < {1'b0, fld(wr_max_addr, int'(ch_q))}) wr_off_d[ch_q] = nxt[BUF_SHIFT-1:0];
          else begin
            wr_off_d[ch_q] = fld(wr_min_addr, int'(ch_q));
`ifdef SDRAM_MPORT_BUFROT_EN
            last_done_d[ch_q] = wr_buf_q[ch_q];
            done_valid_d[ch_q] = 1'b1;
            wr_buf_d[ch_q] = next_wbuf(wr_buf_q[ch_q], rd_buf_q[ch_q]);
`endif
          end
        end else if (!kill_q) begin
          nxt = {1'b0, rd_off_q[ch_q]} + OW'(rd_length);
          if (nxt < {1'b0, fld(rd_max_addr, int'(ch_q))}) rd_off_d[ch_q] = nxt[BUF_SHIFT-1:0];
          else begin
            rd_off_d[ch_q] = fld(rd_min_addr, int'(ch_q));
`ifdef SDRAM_MPORT_BUFROT_EN
            if (done_valid_q[ch_q]) rd_buf_d[ch_q] = last_done_q[ch_q];
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load landing on the channel in flight voids that burst's offset advance.
    if (state_q != S_IDLE && (dir_q ? wr_edge_q[ch_q] : rd_edge_q[ch_q])) kill_d = 1'b1;

    for (int i = 0; i < CH; i++) begin
      if (wr_edge_q[i]) begin
        wr_off_d[i] = fld(wr_min_addr, i);
`ifdef SDRAM_MPORT_BUFROT_EN
        wr_buf_d[i] = '0;
        done_valid_d[i] = 1'b0;
`endif
      end
      if (rd_edge_q[i]) begin
        rd_off_d[i] = fld(rd_min_addr, i);
`ifdef SDRAM_MPORT_BUFROT_EN
        rd_buf_d[i] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q <= S_IDLE;  dir_q <= 1'b0;  ch_q <= '0;
      wr_rr_q <= CH_W'(CH-1);  rd_rr_q <= CH_W'(CH-1);
      wr_req_q <= 1'b0;  rd_req_q <= 1'b0;
      wr_addr_q <= '0;  rd_addr_q <= '0;
      kill_q <= 1'b0;  ack_r_q <= 1'b0;
      wr_load_r_q <= '0;  rd_load_r_q <= '0;
      wr_edge_q <= '0;  rd_edge_q <= '0;
      wrf_clr_q <= '0;  rdf_clr_q <= '0;
      for (int i = 0; i < CH; i++) begin
        wr_off_q[i] <= '0;
        rd_off_q[i] <= '0;
`ifdef SDRAM_MPORT_BUFROT_EN
        wr_buf_q[i] <= '0;
        rd_buf_q[i] <= '0;
        last_done_q[i] <= '0;
`endif
      end
`ifdef SDRAM_MPORT_BUFROT_EN
      done_valid_q <= '0;
`endif
    end else begin
      state_q <= state_d;  dir_q <= dir_d;  ch_q <= ch_d;
      wr_rr_q <= wr_rr_d;  rd_rr_q <= rd_rr_d;
      wr_req_q <= wr_req_d;  rd_req_q <= rd_req_d;
      wr_addr_q <= wr_addr_d;  rd_addr_q <= rd_addr_d;
      kill_q <= kill_d;  ack_r_q <= ack_r_d;
      wr_load_r_q <= wr_load_r_d;  rd_load_r_q <= rd_load_r_d;
      wr_edge_q <= wr_edge_d;  rd_edge_q <= rd_edge_d;
      wrf_clr_q <= wrf_clr_d;  rdf_clr_q <= rdf_clr_d;
      wr_off_q <= wr_off_d;  rd_off_q <= rd_off_d;
`ifdef SDRAM_MPORT_BUFROT_EN
      wr_buf_q <= wr_buf_d;  rd_buf_q <= rd_buf_d;
      last_done_q <= last_done_d;  done_valid_q <= done_valid_d;
`endif
    end
  end

  assign sdram_wr_req  = wr_req_q;
  assign sdram_rd_req  = rd_req_q;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_rd_addr = rd_addr_q;
  assign sdram_ch      = ch_q;
  assign wrf_clr       = wrf_clr_q;
  assign rdf_clr       = rdf_clr_q;

endmodule
